serial_transmitter: RTL
=======================

Name: serial_transmitter

Overview:
- Parallel-to-serial frame transmitter; the transmit-side counterpart of the serial-in/parallel-out shift register receiver.
- Accepts a WIDTH-bit word through a ready/send handshake and shifts it out on a single line at a programmable bit period.
- Frame format: start bit, data bits, optional parity bit, stop bit.
- Emits a mid-bit strobe so a SIPO shift register can capture each data bit directly; used for inter-block serial links and loopback tests.

Parameters:
- WIDTH, 8, data word width in bits; must be >= 2.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- send  input  1  request to transmit D; sampled only when ready=1.
- D  input  WIDTH  word to transmit; captured on accept.
- left  input  1  bit order, captured on accept: 1 = MSB first, 0 = LSB first.
- ready  output  1  high when idle and able to accept a word.
- busy  output  1  high while a frame is in progress (inverse of ready).
- serial  output  1  serial line; idles high.
- bit_strobe  output  1  one-cycle pulse at the middle of each data bit.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, serial=1, ready=1, busy=0, bit_strobe=0, done=0, all counters 0.
- Reset mid-frame: aborts the frame immediately (asynchronously); serial returns to 1; no done pulse.
- Accept: occurs in a cycle where state=IDLE and send=1.
  - D and left are latched into an internal shift register and order flag.
  - After accept, changes on D and left have no effect until the next accept.
- send while busy is ignored, not queued.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0; each non-IDLE state lasts exactly CLKS_PER_BIT cycles per bit.
- START: serial=0.
- DATA: WIDTH bits sent; serial = current MSB (left=1) or LSB (left=0) of the shift register.
  - Register shifts by one at each bit-timer wrap.
  - Bit index counter 0..WIDTH-1; DATA exits after index WIDTH-1 wraps.
- STOP: serial=1.
- Timing (accept in cycle 0):
  - start bit occupies cycles 1..CLKS_PER_BIT;
  - data bit k occupies cycles (k+1)*CLKS_PER_BIT+1 .. (k+2)*CLKS_PER_BIT.
- bit_strobe: high only in DATA, in the cycle where bit timer == CLKS_PER_BIT/2 (integer division; CLKS_PER_BIT=1 gives timer 0).
- done: high for the single final STOP cycle.
  - IDLE/ready=1 follows in the next cycle.
  - A send held high is accepted in that IDLE cycle, so back-to-back frames have exactly one idle-high cycle between them.
- Frame length, accept to done inclusive of done, excluding the accept cycle: (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with parity.
- serial, bit_strobe and done are registered outputs (glitch-free). ready and busy are decoded from the state register.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state of CLKS_PER_BIT cycles is inserted between DATA and STOP.
  - serial = XOR of the latched word (even parity: total ones in data plus parity is even).
  - bit_strobe is not asserted during PARITY.
- Undefined: DATA goes directly to STOP; no parity logic is present.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=4, left=0, D=8'hC1, accept cycle 0 -> serial: 0 on cycles 1-4; data 1,0,0,0,0,0,1,1 for 4 cycles each on cycles 5-36; 1 on cycles 37-40; done only at cycle 40; ready=1 at cycle 41.
- Same setup with left=1, D=8'hC1 -> data bits 1,1,0,0,0,0,0,1; bit_strobe pulses on cycles 7,11,...,35 (8 pulses).
- Loopback: serial -> SIPO serial input, bit_strobe -> SIPO en, matching left; D=8'h5A then 8'hC1, both orders -> SIPO Q equals D when done pulses.
- send held high, D=8'h12 then changed to 8'hFF during the frame -> first frame carries 8'h12; second accepted at cycle 41 with 8'hFF; serial high for exactly one cycle (41) between frames.
- reset pulsed at cycle 20 (mid-DATA) -> same-cycle serial=1, ready=1, busy=0, done never pulses; a new send after release transmits correctly from START.
- SERIAL_TX_PARITY_EN defined, D=8'hC1 -> parity bit 1 on cycles 37-40, stop on 41-44, done at cycle 44; D=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_transmitter.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, optional parity bit, stop bit.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module serial_transmitter #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             send,
  input  logic [WIDTH-1:0] D,
  input  logic             left,
  output logic             ready,
  output logic             busy,
  output logic             serial,
  output logic             bit_strobe,
  output logic             done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(WIDTH);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_transmitter: WIDTH must be >= 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("serial_transmitter: CLKS_PER_BIT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [IW-1:0]    r_index;
  logic [WIDTH-1:0] r_shift;
  logic             r_msb_first;
  logic             r_serial;
  logic             r_strobe;
  logic             r_done;

  state_t           w_state_n;
  logic [TW-1:0]    w_timer_n;
  logic [IW-1:0]    w_index_n;
  logic [WIDTH-1:0] w_shift_n;
  logic             w_msb_first_n;
  logic             w_serial_n;
  logic             w_strobe_n;
  logic             w_done_n;
  logic             w_timer_wrap;
  logic             w_accept;

`ifdef SERIAL_TX_PARITY_EN
  logic r_parity;
  logic w_parity_n;
`endif

  assign w_timer_wrap = (r_timer == T_LAST);
  assign w_accept     = (r_state == S_IDLE) && send;

  // Next-state and datapath. The registered outputs below are computed from
  // these next values so serial/bit_strobe/done line up with the state they describe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_n     = r_state;
    w_timer_n     = r_timer;
    w_index_n     = r_index;
    w_shift_n     = r_shift;
    w_msb_first_n = r_msb_first;

    if (r_state != S_IDLE) begin
      w_timer_n = w_timer_wrap ? '0 : r_timer + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        w_index_n = '0;
        if (send) begin
          w_state_n     = S_START;
          w_shift_n     = D;
          w_msb_first_n = left;
        end
      end
      S_START: begin
        if (w_timer_wrap) begin
          w_state_n = S_DATA;
          w_index_n = '0;
        end
      end
      S_DATA: begin
        if (w_timer_wrap) begin
          w_shift_n = r_msb_first ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};
          if (r_index == I_LAST) begin
            w_index_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_index_n = r_index + IW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_timer_wrap) begin
          w_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_timer_wrap) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_timer_n = '0;
        w_index_n = '0;
      end
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  assign w_parity_n = w_accept ? ^D : r_parity;
`endif

  always_comb begin
    w_serial_n = 1'b1;
    case (w_state_n)
      S_START:  w_serial_n = 1'b0;
      S_DATA:   w_serial_n = w_msb_first_n ? w_shift_n[WIDTH-1] : w_shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_serial_n = w_parity_n;
`endif
      default:  w_serial_n = 1'b1;
    endcase
  end

  assign w_strobe_n = (w_state_n == S_DATA) && (w_timer_n == T_MID);
  assign w_done_n   = (w_state_n == S_STOP) && (w_timer_n == T_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_index     <= '0;
      r_shift     <= '0;
      r_msb_first <= 1'b0;
      r_serial    <= 1'b1;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_timer     <= w_timer_n;
      r_index     <= w_index_n;
      r_shift     <= w_shift_n;
      r_msb_first <= w_msb_first_n;
      r_serial    <= w_serial_n;
      r_strobe    <= w_strobe_n;
      r_done      <= w_done_n;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_n;
    end
  end
`endif

  assign ready      = (r_state == S_IDLE);
  assign busy       = ~ready;
  assign serial     = r_serial;
  assign bit_strobe = r_strobe;
  assign done       = r_done;

endmodule
